ps2_device_tx: RTL and testbench
================================

PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

Interface
REQ-001 SHALL have parameter HALF_CYCLES, default 1000, meaning clock cycles per PS/2 clock half-period (low or high phase).
REQ-002 SHALL have parameter IDLE_CYCLES, default 1250, meaning clock cycles both lines must read high before a frame starts.
REQ-003 SHALL have port clock  input  1  the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port tx_data  input  8  scan-code byte to queue.
REQ-006 SHALL have port tx_valid  input  1  push request; the byte is accepted when tx_valid and tx_ready are both 1.
REQ-007 SHALL have port tx_ready  output  1  1 when the FIFO is not full.
REQ-008 SHALL have port fifo_count  output  4  bytes queued, 0..8.
REQ-009 SHALL have port ps2_clock_in  input  1  sensed PS/2 clock line, asynchronous.
REQ-010 SHALL have port ps2_data_in  input  1  sensed PS/2 data line, asynchronous.
REQ-011 SHALL have port ps2_clock_out  output  1  0 = drive the clock line low; 1 = release it.
REQ-012 SHALL have port ps2_data_out  output  1  0 = drive the data line low; 1 = release it.
REQ-013 SHALL have port busy  output  1  1 while a frame is in progress.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when a frame completes.
REQ-015 SHALL have port frame_abort  output  1  one-cycle pulse when the host inhibits a frame.
REQ-016 SHALL have port host_rts  output  1  1 while the host signals request-to-send.

Function
REQ-017 SHALL pass ps2_clock_in and ps2_data_in through 2-flop synchronizers; all line decisions use the synchronized values.
REQ-018 SHALL implement an 8-entry FIFO.
- Push when tx_valid and tx_ready are both 1.
- Pop only on frame_done.
- When full, a simultaneous push and pop SHALL both take effect and fifo_count SHALL stay 8.
REQ-019 SHALL use states IDLE, WAIT_BUS, SETUP, CLK_LOW and END.
REQ-020 IDLE: when fifo_count>0 and host_rts=0, SHALL go to WAIT_BUS.
REQ-021 WAIT_BUS: SHALL count cycles while both synchronized lines are high, and reset the count to 0 on any low sample.
- At IDLE_CYCLES: bit index=0, go to SETUP.
REQ-022 SETUP: clock line released; ps2_data_out = frame bit[index]; hold for HALF_CYCLES, then go to CLK_LOW.
REQ-023 Frame bits SHALL be sent in this order:
- index 0: start bit, 0;
- index 1..8: FIFO head byte, LSB first;
- index 9: odd parity, so the total count of ones in data+parity is odd;
- index 10: stop bit, 1.
REQ-024 CLK_LOW: ps2_clock_out=0 for HALF_CYCLES.
- After that, if index<10: increment index, go to SETUP.
- Otherwise: go to END.
REQ-025 END: both lines released for HALF_CYCLES, then pulse frame_done, pop the FIFO and go to IDLE.
REQ-026 Inhibit: if the synchronized clock reads 0 on the last cycle of SETUP with index<=9, the block SHALL:
- release both lines the next cycle;
- pulse frame_abort;
- keep the byte at the FIFO head;
- go to WAIT_BUS, so the whole frame is retransmitted.
REQ-027 Inhibit at index 10 or during END SHALL be ignored; the frame counts as delivered.
REQ-028 host_rts SHALL be 1 in IDLE/WAIT_BUS whenever the synchronized clock=1 and data=0 after a clock-low period of at least HALF_CYCLES. It SHALL clear when data returns to 1.
- While host_rts=1, no frame SHALL start.
REQ-029 busy SHALL be 1 in SETUP, CLK_LOW and END, and 0 otherwise.
REQ-030 The block SHALL never drive a line high; ps2_*_out=1 always means released.

Reset
REQ-031 On reset_n=0, the block SHALL immediately:
- set state=IDLE, FIFO empty, fifo_count=0, tx_ready=1;
- set ps2_clock_out=1, ps2_data_out=1;
- set busy=0, frame_done=0, frame_abort=0, host_rts=0;
- clear all counters.
REQ-032 Reset asserted mid-frame SHALL release both lines in the same cycle, with no partial frame resumed after deassertion.

Verification
REQ-033 Push 0x1C with both lines high. Required response:
- frame starts IDLE_CYCLES+2 cycles later;
- data bits at the clock-low phases are 0,0,0,1,1,1,0,0,0,0,1;
- exactly 11 clock-low pulses of HALF_CYCLES each;
- frame_done pulses once; fifo_count returns to 0.
REQ-034 Push 9 bytes back-to-back. Required response:
- 8 accepted, tx_ready=0 after the 8th;
- after the first frame_done, tx_ready=1 and fifo_count=7;
- bytes transmitted in push order.
REQ-035 Pull ps2_clock_in low during the SETUP phase of index 4 (byte 0xF0). Required response:
- frame_abort pulses and both outputs are 1 within 1 cycle;
- after the host releases the clock and IDLE_CYCLES elapse, 0xF0 is retransmitted in full;
- fifo_count stays 1 until frame_done.
REQ-036 Hold the clock low for 2*HALF_CYCLES, drive data low, then release the clock while one byte is queued. Required response:
- host_rts=1 and busy stays 0;
- after data goes high, the byte transmits.
REQ-037 Assert reset_n=0 during CLK_LOW of index 6. Required response:
- both outputs go 1 asynchronously;
- fifo_count=0;
- no frame_done pulse after release.
REQ-038 Pull the clock low during the index-10 SETUP phase. Required response: no abort, frame_done pulses, byte popped.

Source files
------------

// File: rtl/ps2_device_tx.sv
// ps2_device_tx: PS/2 device-side transmitter with an 8-byte FIFO, host inhibit and request-to-send detection
module ps2_device_tx #(
  parameter int HALF_CYCLES = 1000,
  parameter int IDLE_CYCLES = 1250
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [3:0] fifo_count,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_out,
  output logic       ps2_data_out,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_abort,
  output logic       host_rts
);
  localparam int HW = $clog2(HALF_CYCLES + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  typedef enum logic [2:0] {S_IDLE, S_WAIT_BUS, S_SETUP, S_CLK_LOW, S_END} state_t;
  state_t      state_q;
  logic [1:0]  clk_sync_q, dat_sync_q;
  logic        clk_s, dat_s;
  logic [7:0]  mem_q [8];
  logic [2:0]  wr_q, rd_q;
  logic [3:0]  count_q, count_d;
  logic        push, pop;
  logic [7:0]  head;
  logic [10:0] frame;
  logic [HW-1:0] half_q, low_q;
  logic [IW-1:0] idle_q;
  logic [3:0]  idx_q;
  logic        clk_out_q, dat_out_q, busy_q, done_q, abort_q, rts_q;
  assign clk_s    = clk_sync_q[1];
  assign dat_s    = dat_sync_q[1];
  // The pop slot also frees a place, so a full FIFO can accept a byte on the pop cycle
  assign pop      = (state_q == S_END) && (half_q == HW'(HALF_CYCLES - 1));
  assign tx_ready = (count_q != 4'd8) || pop;
  assign push     = tx_valid && tx_ready;
  assign count_d  = count_q + 4'(push) - 4'(pop);
  assign head     = mem_q[rd_q];
  assign frame    = {1'b1, ~^head, head, 1'b0};
  assign fifo_count    = count_q;
  assign ps2_clock_out = clk_out_q;
  assign ps2_data_out  = dat_out_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_abort   = abort_q;
  assign host_rts      = rts_q;
  // Two-flop synchronizers; lines idle high so they reset to 1
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clock_in};
      dat_sync_q <= {dat_sync_q[0], ps2_data_in};
    end
  end
  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= tx_data;
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + 3'(push);
      rd_q    <= rd_q + 3'(pop);
      count_q <= count_d;
    end
  end
  // Request-to-send: clock held low long enough, then released with data still low
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      low_q <= '0;
      rts_q <= 1'b0;
    end else begin
      if (!clk_s) begin
        if (low_q != HW'(HALF_CYCLES)) low_q <= low_q + HW'(1);
      end else if (dat_s) begin
        low_q <= '0;
      end
      rts_q <= (state_q == S_IDLE || state_q == S_WAIT_BUS) && clk_s && !dat_s &&
               (low_q == HW'(HALF_CYCLES));
    end
  end
  // Frame sequencer with registered line drivers and status pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idle_q    <= '0;
      half_q    <= '0;
      idx_q     <= '0;
      clk_out_q <= 1'b1;
      dat_out_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (count_q != 4'd0 && !rts_q) begin
            state_q <= S_WAIT_BUS;
            idle_q  <= '0;
          end
        end
        S_WAIT_BUS: begin
          if (!(clk_s && dat_s)) begin
            idle_q <= '0;
          end else if (idle_q == IW'(IDLE_CYCLES)) begin
            state_q   <= S_SETUP;
            idx_q     <= '0;
            half_q    <= '0;
            dat_out_q <= frame[0];
            busy_q    <= 1'b1;
          end else begin
            idle_q <= idle_q + IW'(1);
          end
        end
        S_SETUP: begin
          if (half_q == HW'(HALF_CYCLES - 1)) begin
            half_q <= '0;
            if (!clk_s && idx_q <= 4'd9) begin
              state_q   <= S_WAIT_BUS;
              idle_q    <= '0;
              dat_out_q <= 1'b1;
              busy_q    <= 1'b0;
              abort_q   <= 1'b1;
            end else begin
              state_q   <= S_CLK_LOW;
              clk_out_q <= 1'b0;
            end
          end else begin
            half_q <= half_q + HW'(1);
          end
        end
        S_CLK_LOW: begin
          if (half_q == HW'(HALF_CYCLES - 1)) begin
            half_q    <= '0;
            clk_out_q <= 1'b1;
            if (idx_q < 4'd10) begin
              idx_q     <= idx_q + 4'd1;
              dat_out_q <= frame[idx_q + 4'd1];
              state_q   <= S_SETUP;
            end else begin
              dat_out_q <= 1'b1;
              state_q   <= S_END;
            end
          end else begin
            half_q <= half_q + HW'(1);
          end
        end
        S_END: begin
          if (half_q == HW'(HALF_CYCLES - 1)) begin
            half_q  <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            half_q <= half_q + HW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_device_tx.sv
// tb_ps2_device_tx: directed vector bench for the PS/2 device transmitter
module tb_ps2_device_tx;
  localparam int HALF = 8;
  localparam int IDLE = 10;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_ready;
  logic [3:0] fifo_count;
  logic host_clk = 1'b1, host_dat = 1'b1;
  logic ps2_clock_in, ps2_data_in, ps2_clock_out, ps2_data_out;
  logic busy, frame_done, frame_abort, host_rts;
  assign ps2_clock_in = ps2_clock_out & host_clk;
  assign ps2_data_in  = ps2_data_out & host_dat;
  ps2_device_tx #(.HALF_CYCLES(HALF), .IDLE_CYCLES(IDLE)) dut (
    .clock(clock), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .fifo_count(fifo_count), .ps2_clock_in(ps2_clock_in),
    .ps2_data_in(ps2_data_in), .ps2_clock_out(ps2_clock_out), .ps2_data_out(ps2_data_out),
    .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort), .host_rts(host_rts)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;
  vec_t tab [8];
  int checks = 0, errors = 0;
  int npulse = 0, low_w = 0, bad_w = 0, ndone = 0, nabort = 0;
  logic [10:0] cap = '0;
  logic prev_c = 1'b1;
  always @(negedge clock) begin
    if (prev_c && !ps2_clock_out) begin
      cap = {ps2_data_out, cap[10:1]};
      npulse++;
    end
    if (!ps2_clock_out) low_w++;
    else if (!prev_c) begin
      if (low_w != HALF) bad_w++;
      low_w = 0;
    end
    ndone  += int'(frame_done);
    nabort += int'(frame_abort);
    prev_c = ps2_clock_out;
  end
  task automatic tick();
    @(negedge clock);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic clr();
    npulse = 0;
    bad_w = 0;
    cap = '0;
  endtask
  task automatic push(input logic [7:0] b);
    tx_data = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask
  task automatic wait_done(input int n);
    int i;
    for (i = 0; i < 3000 && ndone < n; i++) tick();
    chk("done_wait", 32'(ndone >= n), 1);
  endtask
  initial begin
    int lat, base_d, base_a, i;
    tab[0] = '{8'h1C, 11'h438};
    tab[1] = '{8'h00, 11'h600};
    tab[2] = '{8'hFF, 11'h7FE};
    tab[3] = '{8'hA5, 11'h74A};
    tab[4] = '{8'h80, 11'h500};
    tab[5] = '{8'hF0, 11'h7E0};
    tab[6] = '{8'h01, 11'h402};
    tab[7] = '{8'h5A, 11'h6B4};
    repeat (3) tick();
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_clk_out", 32'(ps2_clock_out), 1);
    chk("rst_dat_out", 32'(ps2_data_out), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", {29'd0, frame_done, frame_abort, host_rts}, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    for (int v = 0; v < 8; v++) begin
      clr();
      base_d = ndone;
      push(tab[v].data);
      chk("count_one", 32'(fifo_count), 1);
      lat = 0;
      while (!busy && lat < 1000) begin
        tick();
        lat++;
      end
      chk("start_lat", 32'(lat), 32'(IDLE + 2));
      wait_done(base_d + 1);
      chk("frame_bits", 32'(cap), 32'(tab[v].frame));
      chk("pulses", 32'(npulse), 11);
      chk("low_width", 32'(bad_w), 0);
      chk("count_zero", 32'(fifo_count), 0);
      repeat (3) tick();
      chk("single_done", 32'(ndone - base_d), 1);
    end
    clr();
    base_d = ndone;
    for (int k = 0; k < 9; k++) begin
      tx_data = (k < 8) ? tab[k].data : 8'h77;
      tx_valid = 1'b1;
      tick();
      if (k == 7) chk("full_ready", 32'(tx_ready), 0);
    end
    tx_valid = 1'b0;
    chk("full_count", 32'(fifo_count), 8);
    for (int k = 0; k < 8; k++) begin
      wait_done(base_d + k + 1);
      if (k == 0) begin
        chk("pop_ready", 32'(tx_ready), 1);
        chk("pop_count", 32'(fifo_count), 7);
      end
      chk("order_bits", 32'(cap), 32'(tab[k].frame));
      chk("order_pulses", 32'(npulse), 11);
      clr();
    end
    repeat (200) tick();
    chk("drained", 32'(fifo_count), 0);
    chk("no_ninth", 32'(ndone - base_d), 8);
    clr();
    base_a = nabort;
    base_d = ndone;
    push(8'hF0);
    for (i = 0; i < 1000 && !(npulse == 4 && ps2_clock_out); i++) tick();
    chk("reach_idx4", 32'(i < 1000), 1);
    host_clk = 1'b0;
    for (i = 0; i < 3 * HALF && nabort == base_a; i++) tick();
    chk("abort_pulse", 32'(nabort - base_a), 1);
    chk("abort_clk", 32'(ps2_clock_out), 1);
    chk("abort_dat", 32'(ps2_data_out), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_count", 32'(fifo_count), 1);
    repeat (20) tick();
    chk("held_count", 32'(fifo_count), 1);
    chk("held_done", 32'(ndone - base_d), 0);
    host_clk = 1'b1;
    clr();
    wait_done(base_d + 1);
    chk("retx_bits", 32'(cap), 11'h7E0);
    chk("retx_pulses", 32'(npulse), 11);
    chk("retx_abort", 32'(nabort - base_a), 1);
    chk("retx_count", 32'(fifo_count), 0);
    base_d = ndone;
    host_clk = 1'b0;
    push(8'hA5);
    repeat (2 * HALF) tick();
    host_dat = 1'b0;
    repeat (2) tick();
    host_clk = 1'b1;
    repeat (3 * IDLE) tick();
    chk("rts_set", 32'(host_rts), 1);
    chk("rts_busy", 32'(busy), 0);
    chk("rts_done", 32'(ndone - base_d), 0);
    clr();
    host_dat = 1'b1;
    repeat (3) tick();
    chk("rts_clear", 32'(host_rts), 0);
    wait_done(base_d + 1);
    chk("rts_bits", 32'(cap), 11'h74A);
    repeat (5) tick();
    clr();
    base_d = ndone;
    push(8'h1C);
    for (i = 0; i < 1000 && !(npulse == 7 && !ps2_clock_out); i++) tick();
    chk("reach_idx6", 32'(i < 1000), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_clk", 32'(ps2_clock_out), 1);
    chk("arst_dat", 32'(ps2_data_out), 1);
    chk("arst_count", 32'(fifo_count), 0);
    chk("arst_busy", 32'(busy), 0);
    tick();
    reset_n = 1'b1;
    repeat (300) tick();
    chk("arst_no_done", 32'(ndone - base_d), 0);
    chk("arst_idle", 32'(busy), 0);
    clr();
    base_a = nabort;
    base_d = ndone;
    push(8'h80);
    for (i = 0; i < 1000 && !(npulse == 10 && ps2_clock_out); i++) tick();
    chk("reach_idx10", 32'(i < 1000), 1);
    host_clk = 1'b0;
    wait_done(base_d + 1);
    chk("late_no_abort", 32'(nabort - base_a), 0);
    chk("late_count", 32'(fifo_count), 0);
    chk("late_bits", 32'(cap), 11'h500);
    chk("late_pulses", 32'(npulse), 11);
    host_clk = 1'b1;
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
